execute: RTL
============

// Module: execute
// PURPOSE
//  - EX stage of the pipelined MIPS core; consumes decode's control/immediate bundle and produces the fetch redirect (RedirectPc_EX, BranchTaken_EX).
//  - Holds the ID/EX pipeline register, runs the ALU, resolves branches/JR, and squashes the wrong-path instruction after a taken redirect.
//  - No delay slots. Redirect is resolved in EX, giving a 2-instruction penalty; fetch discards IF itself.
// PARAMETERS
//  - XLEN  32  datapath width (fixed at 32; the parameter exists only for the shift/compare width constants)
// PORTS
//  - clk             in   1   core clock, posedge
//  - reset           in   1   asynchronous, active-high
//  - AnyStall        in   1   1 = hold the ID/EX register (no capture)
//  - PcPlus4_ID      in  32   PC+4 of the instruction in ID
//  - RsData_ID       in  32   rs register file read data
//  - RtData_ID       in  32   rt register file read data
//  - Rt_ID, Rd_ID    in   5   destination candidates
//  - Imm_ID          in  16   instr[15:0]; shamt = Imm_ID[10:6]
//  - AluControl_ID   in   4   ALU operation
//  - BpCtl_ID        in   3   branch operation
//  - RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID, Link_ID   in  1 each
//  - RedirectPc_EX   out 32   redirect target
//  - BranchTaken_EX  out  1   redirect fetch to RedirectPc_EX
//  - AluResult_EX    out 32   ALU result, or link address
//  - WriteData_EX    out 32   store data (registered RtData)
//  - WriteReg_EX     out  5   destination register number
//  - RegWrite_EX, MemWrite_EX, MemToReg_EX   out  1   gated by the valid bit
// BEHAVIOUR
//  - Reset clears all ID/EX fields and Valid_EX. As a result every output is 0: BranchTaken_EX=0, RedirectPc_EX=0, WriteReg_EX=0.
//  - Capture: on posedge, if !AnyStall, ID/EX <= ID inputs and Valid_EX <= !BranchTaken_EX.
//    - A taken redirect squashes the wrong-path instruction being captured.
//    - If AnyStall=1, all fields including Valid_EX hold.
//  - All EX outputs are combinational from the ID/EX register, so latency is 1 cycle from ID to EX outputs.
//  - Sign extension: SImm = sext(Imm). Logical ops with AluSrc=1 (AND, OR, XOR) use zext(Imm). SrcB = AluSrc ? Imm_ext : RtData.
//  - AluControl encoding; any other code gives result 0:
//    - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB
//    - 0111 SLT (signed), 1000 SLTU
//    - 1001 SLL, 1010 SRL, 1011 SRA; these shift SrcB by shamt
//    - 1100 LUI = {Imm,16'b0}
//  - Arithmetic is modulo 2^32 with no overflow trap.
//  - BpCtl encoding:
//    - 000 none
//    - 001 BEQ rs==rt, 010 BNE rs!=rt
//    - 011 BLEZ rs<=0, 100 BGTZ rs>0, 101 BLTZ rs<0, 110 BGEZ rs>=0 (signed compares)
//    - 111 JR/JALR: always taken
//  - Target: BpCtl==111 gives RsData; otherwise PcPlus4 + (SImm<<2), wrapping at 2^32.
//  - BranchTaken_EX = Valid_EX & cond. It stays asserted while AnyStall holds EX; repeated redirects to the same target are legal.
//  - RedirectPc_EX is driven even when not taken; it is don't-care to fetch, but must still be 0 after reset.
//  - Link_ID=1 gives AluResult_EX = PcPlus4 and WriteReg_EX = 31, unless this is JALR with RegDst=1, which gives WriteReg = Rd.
//  - Without link: WriteReg_EX = RegDst ? Rd : Rt.
//  - Valid_EX=0 forces RegWrite_EX, MemWrite_EX, MemToReg_EX and BranchTaken_EX to 0.
//  - Taken branch and stall in the same cycle: no capture and no squash yet. On the first non-stalled edge, the ID instruction is captured with Valid=0.
//  - Reset asserted mid-stall or mid-redirect clears everything immediately (async).
// STRUCTURE
//  - Shared package: AluControl and BpCtl encodings as localparams, plus LINK_REG=5'd31.
//  - One sub-module, alu (SrcA, SrcB, shamt, AluControl -> Result), purely combinational.
//  - The ID/EX register and branch compare stay in execute. Use dff instances, with reset values 0.
// TESTING
//  - Reset then ADD: rs=5, rt=7, AluControl=0010, RegDst=1, Rd=3 -> next cycle AluResult_EX=12, WriteReg_EX=3, RegWrite_EX=1.
//  - ADDI negative: rs=1, Imm=16'hFFFF, AluSrc=1 -> AluResult_EX=0. ORI Imm=16'hFFFF, rs=0 -> AluResult_EX=32'h0000FFFF.
//  - BEQ taken: PcPlus4=32'h100, Imm=16'hFFFE, rs=rt=9 -> BranchTaken_EX=1, RedirectPc_EX=32'hF8.
//    - Next-cycle EX instruction (RegWrite=1) has RegWrite_EX=0.
//  - BNE with rs=rt -> BranchTaken_EX=0, and the next instruction retires with valid controls.
//  - BGTZ/BLTZ on rs=32'h80000000: BGTZ not taken, BLTZ taken. SRA shamt=4 of 32'h80000000 -> 32'hF8000000.
//  - JAL-link: Link=1, PcPlus4=32'h40 -> AluResult_EX=32'h40, WriteReg_EX=31.
//  - JR rs=32'h200 held under AnyStall for 3 cycles -> BranchTaken_EX stays 1. The first post-stall capture has Valid=0.
//  - Reset pulse mid-stall -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared encodings for the EX stage: ALU operation codes, branch operation
// codes and the architectural link register number.
package execute_pkg;

  localparam int XLEN_DEF = 32;

  // ALU operation codes (AluControl)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  // Branch operation codes (BpCtl)
  localparam logic [2:0] BP_NONE = 3'b000;
  localparam logic [2:0] BP_BEQ  = 3'b001;
  localparam logic [2:0] BP_BNE  = 3'b010;
  localparam logic [2:0] BP_BLEZ = 3'b011;
  localparam logic [2:0] BP_BGTZ = 3'b100;
  localparam logic [2:0] BP_BLTZ = 3'b101;
  localparam logic [2:0] BP_BGEZ = 3'b110;
  localparam logic [2:0] BP_JR   = 3'b111;

  localparam logic [4:0] LINK_REG = 5'd31;

  // AND/OR/XOR immediates are zero-extended; everything else sign-extends.
  function automatic logic is_logical_op(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the EX stage. Shifts operate on SrcB by shamt;
// LUI places SrcB[15:0] in the upper half. Unknown codes give 0.
module alu
  import execute_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0]         SrcA,
  input  logic [XLEN-1:0]         SrcB,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic [3:0]              AluControl,
  output logic [XLEN-1:0]         Result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = SrcA;
  assign b_s = SrcB;

  // Operation select; arithmetic wraps modulo 2^XLEN.
  always_comb begin
    Result = '0;
    case (AluControl)
      ALU_AND:  Result = SrcA & SrcB;
      ALU_OR:   Result = SrcA | SrcB;
      ALU_ADD:  Result = SrcA + SrcB;
      ALU_XOR:  Result = SrcA ^ SrcB;
      ALU_NOR:  Result = ~(SrcA | SrcB);
      ALU_SUB:  Result = SrcA - SrcB;
      ALU_SLT:  Result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      ALU_SLL:  Result = SrcB << shamt;
      ALU_SRL:  Result = SrcB >> shamt;
      ALU_SRA:  Result = b_s >>> shamt;
      ALU_LUI:  Result = {SrcB[15:0], {(XLEN-16){1'b0}}};
      default:  Result = '0;
    endcase
  end

endmodule

// File: rtl/dff.sv
// Enabled register with asynchronous active-high reset to zero.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d when enabled; reset clears immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/execute.sv
// EX stage: ID/EX pipeline register, ALU, branch/JR resolution and
// wrong-path squash. All EX outputs are combinational from ID/EX.
module execute
  import execute_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            AnyStall,
  input  logic [XLEN-1:0] PcPlus4_ID,
  input  logic [XLEN-1:0] RsData_ID,
  input  logic [XLEN-1:0] RtData_ID,
  input  logic [4:0]      Rt_ID,
  input  logic [4:0]      Rd_ID,
  input  logic [15:0]     Imm_ID,
  input  logic [3:0]      AluControl_ID,
  input  logic [2:0]      BpCtl_ID,
  input  logic            RegWrite_ID,
  input  logic            RegDst_ID,
  input  logic            AluSrc_ID,
  input  logic            MemWrite_ID,
  input  logic            MemToReg_ID,
  input  logic            Link_ID,
  output logic [XLEN-1:0] RedirectPc_EX,
  output logic            BranchTaken_EX,
  output logic [XLEN-1:0] AluResult_EX,
  output logic [XLEN-1:0] WriteData_EX,
  output logic [4:0]      WriteReg_EX,
  output logic            RegWrite_EX,
  output logic            MemWrite_EX,
  output logic            MemToReg_EX
);

  localparam int CTL_W = 6 + 4 + 3 + 5 + 5 + 16;

  logic             capture;
  logic [CTL_W-1:0] ctl_id;
  logic [CTL_W-1:0] ctl_ex;

  logic [XLEN-1:0]  PcPlus4_EX;
  logic [XLEN-1:0]  RsData_EX;
  logic [XLEN-1:0]  RtData_EX;
  logic [4:0]       Rt_EX;
  logic [4:0]       Rd_EX;
  logic [15:0]      Imm_EX;
  logic [3:0]       AluControl_EX;
  logic [2:0]       BpCtl_EX;
  logic             RegWriteRaw_EX;
  logic             RegDst_EX;
  logic             AluSrc_EX;
  logic             MemWriteRaw_EX;
  logic             MemToRegRaw_EX;
  logic             Link_EX;
  logic             Valid_EX;
  logic             valid_d;

  logic [XLEN-1:0]  imm_sext;
  logic [XLEN-1:0]  imm_zext;
  logic [XLEN-1:0]  src_b;
  logic [XLEN-1:0]  alu_result;
  logic [XLEN-1:0]  branch_target;
  logic signed [XLEN-1:0] rs_s;
  logic             cond;

  assign capture = !AnyStall;
  assign ctl_id  = {RegWrite_ID, RegDst_ID, AluSrc_ID, MemWrite_ID, MemToReg_ID,
                    Link_ID, AluControl_ID, BpCtl_ID, Rt_ID, Rd_ID, Imm_ID};

  // A taken redirect marks the instruction being captured as wrong-path.
  assign valid_d = !BranchTaken_EX;

  // ---- ID/EX pipeline register boundary ----
  dff #(.WIDTH(XLEN))  u_pc_ff    (.clk(clk), .reset(reset), .en(capture), .d(PcPlus4_ID), .q(PcPlus4_EX));
  dff #(.WIDTH(XLEN))  u_rs_ff    (.clk(clk), .reset(reset), .en(capture), .d(RsData_ID),  .q(RsData_EX));
  dff #(.WIDTH(XLEN))  u_rt_ff    (.clk(clk), .reset(reset), .en(capture), .d(RtData_ID),  .q(RtData_EX));
  dff #(.WIDTH(CTL_W)) u_ctl_ff   (.clk(clk), .reset(reset), .en(capture), .d(ctl_id),     .q(ctl_ex));
  dff #(.WIDTH(1))     u_valid_ff (.clk(clk), .reset(reset), .en(capture), .d(valid_d),    .q(Valid_EX));

  assign {RegWriteRaw_EX, RegDst_EX, AluSrc_EX, MemWriteRaw_EX, MemToRegRaw_EX,
          Link_EX, AluControl_EX, BpCtl_EX, Rt_EX, Rd_EX, Imm_EX} = ctl_ex;

  // ---- EX combinational datapath ----
  assign imm_sext = {{(XLEN-16){Imm_EX[15]}}, Imm_EX};
  assign imm_zext = {{(XLEN-16){1'b0}}, Imm_EX};

  // LUI always takes the immediate so its result is independent of AluSrc.
  always_comb begin
    src_b = RtData_EX;
    if (AluSrc_EX || (AluControl_EX == ALU_LUI))
      src_b = is_logical_op(AluControl_EX) ? imm_zext : imm_sext;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (RsData_EX),
    .SrcB       (src_b),
    .shamt      (Imm_EX[10:6]),
    .AluControl (AluControl_EX),
    .Result     (alu_result)
  );

  assign rs_s = RsData_EX;

  // Branch condition evaluation (signed compares against zero).
  always_comb begin
    cond = 1'b0;
    case (BpCtl_EX)
      BP_BEQ:  cond = (RsData_EX == RtData_EX);
      BP_BNE:  cond = (RsData_EX != RtData_EX);
      BP_BLEZ: cond = (rs_s <= 0);
      BP_BGTZ: cond = (rs_s > 0);
      BP_BLTZ: cond = (rs_s < 0);
      BP_BGEZ: cond = (rs_s >= 0);
      BP_JR:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign branch_target  = PcPlus4_EX + {imm_sext[XLEN-3:0], 2'b00};
  assign RedirectPc_EX  = (BpCtl_EX == BP_JR) ? RsData_EX : branch_target;
  assign BranchTaken_EX = Valid_EX & cond;

  // Link instructions write PC+4; JALR with RegDst honours rd.
  always_comb begin
    AluResult_EX = alu_result;
    WriteReg_EX  = RegDst_EX ? Rd_EX : Rt_EX;
    if (Link_EX) begin
      AluResult_EX = PcPlus4_EX;
      WriteReg_EX  = ((BpCtl_EX == BP_JR) && RegDst_EX) ? Rd_EX : LINK_REG;
    end
  end

  assign WriteData_EX = RtData_EX;
  assign RegWrite_EX  = Valid_EX & RegWriteRaw_EX;
  assign MemWrite_EX  = Valid_EX & MemWriteRaw_EX;
  assign MemToReg_EX  = Valid_EX & MemToRegRaw_EX;

endmodule
